// File: rtl/rvfi_thread_router.sv
// Routes per-core RVFI commits to per-thread monitor ports and performs
// scheduler-driven pairwise thread swaps between cores once both have drained.
module rvfi_thread_router #(
    parameter int          NUM_CORES = 2,
    parameter int          PKT_W     = 375,
    parameter logic [31:0] RESET_PC  = 32'h1eceb000,
    parameter int          IDX_W     = $clog2(NUM_CORES)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CORES-1:0]                core_valid,
    input  logic [NUM_CORES-1:0][PKT_W-1:0]     core_pkt,
    input  logic [NUM_CORES-1:0][31:0]          core_pc_wdata,
    input  logic [NUM_CORES-1:0]                core_drained,
    input  logic                                swap_req,
    input  logic [IDX_W-1:0]                    swap_a,
    input  logic [IDX_W-1:0]                    swap_b,
    output logic                                swap_ack,
    output logic                                swap_busy,
    output logic [NUM_CORES-1:0]                core_swap_pc,
    output logic [NUM_CORES-1:0][31:0]          core_resume_pc,
    output logic [NUM_CORES-1:0]                mon_valid,
    output logic [NUM_CORES-1:0][PKT_W-1:0]     mon_pkt,
    output logic [NUM_CORES-1:0][IDX_W-1:0]     thread_of_core,
    output logic [NUM_CORES-1:0][63:0]          thread_retired
);

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP, ACK} state_t;

    state_t                          state, state_nxt;
    logic [IDX_W-1:0]                sw_a, sw_b;
    logic                            req_bad;
    logic [NUM_CORES-1:0][31:0]      last_pc;
    logic [NUM_CORES-1:0]            route_valid;
    logic [NUM_CORES-1:0][PKT_W-1:0] route_pkt;
    logic [NUM_CORES-1:0][31:0]      route_pc;

    assign swap_ack  = (state == ACK);
    assign swap_busy = (state != IDLE);

    always_comb begin
        req_bad = (swap_a == swap_b)
               || (32'(swap_a) >= 32'(NUM_CORES))
               || (32'(swap_b) >= 32'(NUM_CORES));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (swap_req) state_nxt = req_bad ? ACK : DRAIN;
            DRAIN:   if (core_drained[sw_a] && core_drained[sw_b]) state_nxt = SWAP;
            SWAP:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sw_a  <= '0;
            sw_b  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && swap_req) begin
                sw_a <= swap_a;
                sw_b <= swap_b;
            end
        end
    end

    // Core-indexed commits scattered onto thread-indexed lanes via the current mapping.
    always_comb begin
        route_valid = '0;
        route_pkt   = '0;
        route_pc    = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            route_valid[thread_of_core[c]] = core_valid[c];
            route_pkt[thread_of_core[c]]   = core_pkt[c];
            route_pc[thread_of_core[c]]    = core_pc_wdata[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                thread_of_core[c] <= IDX_W'(c);
                last_pc[c]        <= RESET_PC;
            end
            thread_retired <= '0;
            mon_valid      <= '0;
            mon_pkt        <= '0;
            core_swap_pc   <= '0;
            core_resume_pc <= '0;
        end else begin
            mon_valid    <= route_valid;
            core_swap_pc <= '0;
            for (int unsigned t = 0; t < NUM_CORES; t++) begin
                if (route_valid[t]) begin
                    mon_pkt[t]        <= route_pkt[t];
                    last_pc[t]        <= route_pc[t];
                    thread_retired[t] <= thread_retired[t] + 64'd1;
                end
            end
            if (state == SWAP) begin
                thread_of_core[sw_a] <= thread_of_core[sw_b];
                thread_of_core[sw_b] <= thread_of_core[sw_a];
                // A commit in this cycle has not reached last_pc yet, so take it directly.
                core_resume_pc[sw_a] <= core_valid[sw_b] ? core_pc_wdata[sw_b]
                                                         : last_pc[thread_of_core[sw_b]];
                core_resume_pc[sw_b] <= core_valid[sw_a] ? core_pc_wdata[sw_a]
                                                         : last_pc[thread_of_core[sw_a]];
                core_swap_pc[sw_a]   <= 1'b1;
                core_swap_pc[sw_b]   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_thread_router.sv
// Directed swap sequences over randomized commit traffic, checked against a
// thread-level reference model (mapping array, per-thread last pc and counters).
module tb_rvfi_thread_router;

    localparam int          N   = 4;
    localparam int          IW  = 2;
    localparam int          N3  = 3;
    localparam int          PW  = 375;
    localparam logic [31:0] RPC = 32'h1eceb000;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N-1:0]              core_valid;
    logic [N-1:0][PW-1:0]      core_pkt;
    logic [N-1:0][31:0]        core_pc_wdata;
    logic [N-1:0]              core_drained;
    logic                      swap_req;
    logic [IW-1:0]             swap_a, swap_b;
    logic                      swap_ack, swap_busy;
    logic [N-1:0]              core_swap_pc;
    logic [N-1:0][31:0]        core_resume_pc;
    logic [N-1:0]              mon_valid;
    logic [N-1:0][PW-1:0]      mon_pkt;
    logic [N-1:0][IW-1:0]      thread_of_core;
    logic [N-1:0][63:0]        thread_retired;

    logic [N3-1:0]             d3_core_valid;
    logic [N3-1:0][PW-1:0]     d3_core_pkt;
    logic [N3-1:0][31:0]       d3_core_pc_wdata;
    logic [N3-1:0]             d3_core_drained;
    logic                      d3_swap_req;
    logic [1:0]                d3_swap_a, d3_swap_b;
    logic                      d3_swap_ack, d3_swap_busy;
    logic [N3-1:0]             d3_core_swap_pc;
    logic [N3-1:0][31:0]       d3_core_resume_pc;
    logic [N3-1:0]             d3_mon_valid;
    logic [N3-1:0][PW-1:0]     d3_mon_pkt;
    logic [N3-1:0][1:0]        d3_thread_of_core;
    logic [N3-1:0][63:0]       d3_thread_retired;

    rvfi_thread_router #(.NUM_CORES(N), .PKT_W(PW), .RESET_PC(RPC)) u_dut (
        .clk(clk), .rst(rst), .core_valid(core_valid), .core_pkt(core_pkt),
        .core_pc_wdata(core_pc_wdata), .core_drained(core_drained),
        .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b),
        .swap_ack(swap_ack), .swap_busy(swap_busy), .core_swap_pc(core_swap_pc),
        .core_resume_pc(core_resume_pc), .mon_valid(mon_valid), .mon_pkt(mon_pkt),
        .thread_of_core(thread_of_core), .thread_retired(thread_retired)
    );

    rvfi_thread_router #(.NUM_CORES(N3), .PKT_W(PW), .RESET_PC(RPC)) u_dut3 (
        .clk(clk), .rst(rst), .core_valid(d3_core_valid), .core_pkt(d3_core_pkt),
        .core_pc_wdata(d3_core_pc_wdata), .core_drained(d3_core_drained),
        .swap_req(d3_swap_req), .swap_a(d3_swap_a), .swap_b(d3_swap_b),
        .swap_ack(d3_swap_ack), .swap_busy(d3_swap_busy), .core_swap_pc(d3_core_swap_pc),
        .core_resume_pc(d3_core_resume_pc), .mon_valid(d3_mon_valid), .mon_pkt(d3_mon_pkt),
        .thread_of_core(d3_thread_of_core), .thread_retired(d3_thread_retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: thread-level view of the router.
    int unsigned       m_map  [N];
    logic [31:0]       m_last [N];
    logic [63:0]       m_ret  [N];
    logic [PW-1:0]     m_pkt  [N];
    logic              m_mv   [N];
    logic [31:0]       m_res  [N];
    logic [N-1:0]      m_swp;
    logic              swap_now = 1'b0;
    int unsigned       sw_ma, sw_mb;
    logic              e3_busy = 1'b0, e3_ack = 1'b0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_map[i]  = i;
            m_last[i] = RPC;
            m_ret[i]  = '0;
            m_pkt[i]  = '0;
            m_mv[i]   = 1'b0;
            m_res[i]  = '0;
        end
        m_swp = '0;
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] p = '0;
        for (int i = 0; i < 12; i++) p = {p[PW-33:0], 32'($urandom)};
        return p;
    endfunction

    task automatic rand_inputs();
        for (int c = 0; c < N; c++) begin
            core_valid[c]    = 1'($urandom_range(0, 1));
            core_pc_wdata[c] = 32'($urandom);
            core_pkt[c]      = rand_pkt();
        end
    endtask

    task automatic tick(input logic e_busy, input logic e_ack);
        int unsigned ta, tb;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int t = 0; t < N; t++) m_mv[t] = 1'b0;
            for (int c = 0; c < N; c++) begin
                if (core_valid[c]) begin
                    m_mv[m_map[c]]   = 1'b1;
                    m_pkt[m_map[c]]  = core_pkt[c];
                    m_last[m_map[c]] = core_pc_wdata[c];
                    m_ret[m_map[c]]  = m_ret[m_map[c]] + 64'd1;
                end
            end
            m_swp = '0;
            if (swap_now) begin
                ta = m_map[sw_ma];
                tb = m_map[sw_mb];
                m_map[sw_ma] = tb;
                m_map[sw_mb] = ta;
                m_res[sw_ma] = m_last[tb];
                m_res[sw_mb] = m_last[ta];
                m_swp[sw_ma] = 1'b1;
                m_swp[sw_mb] = 1'b1;
            end
        end
        #1;
        for (int t = 0; t < N; t++) begin
            chk($sformatf("mon_valid[%0d]", t), mon_valid[t], m_mv[t]);
            chk($sformatf("mon_pkt[%0d]", t), mon_pkt[t], m_pkt[t]);
            chk($sformatf("thread_retired[%0d]", t), thread_retired[t], m_ret[t]);
        end
        for (int c = 0; c < N; c++) begin
            chk($sformatf("thread_of_core[%0d]", c), thread_of_core[c], m_map[c]);
            chk($sformatf("core_resume_pc[%0d]", c), core_resume_pc[c], m_res[c]);
        end
        chk("core_swap_pc", core_swap_pc, m_swp);
        chk("swap_busy", swap_busy, e_busy);
        chk("swap_ack", swap_ack, e_ack);
        chk("d3_swap_busy", d3_swap_busy, e3_busy);
        chk("d3_swap_ack", d3_swap_ack, e3_ack);
        chk("d3_core_swap_pc", d3_core_swap_pc, 3'b000);
        chk("d3_thread_of_core", d3_thread_of_core, 6'b10_01_00);
    endtask

    // mode: 0 normal, 1 reset in DRAIN, 2 reset in SWAP, 3 forced pc 0x100 on core b in SWAP
    task automatic do_swap(input int unsigned a, input int unsigned b, input int n, input int mode);
        logic [N-1:0] partial;
        partial = ~(N'(1) << b);
        rand_inputs();
        swap_req = 1'b1;
        swap_a = IW'(a);
        swap_b = IW'(b);
        core_drained = partial;
        tick(1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            tick(1'b1, 1'b0);
        end
        if (mode == 1) begin
            rand_inputs();
            rst = 1'b1;
            tick(1'b0, 1'b0);
            rst = 1'b0;
            swap_req = 1'b0;
            rand_inputs();
            tick(1'b0, 1'b0);
            chk("map_identity_after_rst", thread_of_core, 8'b11_10_01_00);
            return;
        end
        rand_inputs();
        core_drained = '1;
        tick(1'b1, 1'b0);
        rand_inputs();
        core_valid = '1;
        if (mode == 3) core_pc_wdata[b] = 32'h100;
        swap_now = 1'b1;
        sw_ma = a;
        sw_mb = b;
        if (mode == 2) begin
            rst = 1'b1;
            tick(1'b0, 1'b0);
            swap_now = 1'b0;
            rst = 1'b0;
            swap_req = 1'b0;
            rand_inputs();
            tick(1'b0, 1'b0);
            return;
        end
        tick(1'b1, 1'b1);
        swap_now = 1'b0;
        if (mode == 3) chk("resume_bypass_0x100", core_resume_pc[a], 32'h100);
        swap_req = 1'b0;
        core_drained = '0;
        rand_inputs();
        tick(1'b0, 1'b0);
    endtask

    task automatic do_bad4(input int unsigned a, input int unsigned b);
        rand_inputs();
        swap_req = 1'b1;
        swap_a = IW'(a);
        swap_b = IW'(b);
        core_drained = '1;
        tick(1'b1, 1'b1);
        swap_req = 1'b0;
        rand_inputs();
        tick(1'b0, 1'b0);
    endtask

    task automatic do_bad3(input int unsigned a, input int unsigned b);
        d3_swap_req = 1'b1;
        d3_swap_a = 2'(a);
        d3_swap_b = 2'(b);
        e3_busy = 1'b1;
        e3_ack = 1'b1;
        rand_inputs();
        tick(1'b0, 1'b0);
        d3_swap_req = 1'b0;
        e3_busy = 1'b0;
        e3_ack = 1'b0;
        rand_inputs();
        tick(1'b0, 1'b0);
    endtask

    initial begin
        int unsigned ra, rb;
        rst = 1'b1;
        core_valid = '0; core_pkt = '0; core_pc_wdata = '0; core_drained = '0;
        swap_req = 1'b0; swap_a = '0; swap_b = '0;
        d3_core_valid = '0; d3_core_pkt = '0; d3_core_pc_wdata = '0; d3_core_drained = '1;
        d3_swap_req = 1'b0; d3_swap_a = '0; d3_swap_b = '0;
        model_reset();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b0;

        // First commit after reset lands on thread 0.
        core_valid = 4'b0001;
        core_pc_wdata[0] = 32'h1eceb004;
        core_pkt[0] = rand_pkt();
        tick(1'b0, 1'b0);
        chk("first_commit_mon_valid", mon_valid, 4'b0001);
        chk("first_commit_retired0", thread_retired[0], 64'd1);

        repeat (20) begin
            rand_inputs();
            tick(1'b0, 1'b0);
        end

        do_swap(0, 1, 3, 0);
        core_valid = 4'b0010;
        tick(1'b0, 1'b0);
        chk("core1_to_thread0", mon_valid, 4'b0001);
        core_valid = 4'b0001;
        tick(1'b0, 1'b0);
        chk("core0_to_thread1", mon_valid, 4'b0010);

        do_swap(0, 1, 1, 3);
        do_bad4(1, 1);
        do_bad3(3, 0);
        do_bad3(1, 1);

        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        do_swap(0, 2, 2, 0);
        do_swap(2, 3, 0, 0);
        chk("map_after_two_swaps", thread_of_core, 8'b00_11_01_10);

        do_swap(1, 3, 2, 1);
        do_swap(3, 0, 1, 2);
        chk("map_after_swap_rst", thread_of_core, 8'b11_10_01_00);

        repeat (8) begin
            ra = $urandom_range(0, N - 1);
            rb = (ra + $urandom_range(1, N - 1)) % N;
            do_swap(ra, rb, int'($urandom_range(0, 4)), 0);
            repeat (3) begin
                rand_inputs();
                tick(1'b0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
